hamming_encode_arbiter: RTL and testbench

HAMMING_ENCODE_ARBITER -- requirements
Module: hamming_encode_arbiter

---
 rtl/hamming_encode_arbiter_pkg.sv | 8 +
 rtl/hamming_encode_arbiter_encoder.sv | 22 ++
 rtl/hamming_encode_arbiter.sv | 98 +++++++++
 tb/tb_hamming_encode_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/hamming_encode_arbiter_pkg.sv
// Shared constants and word types for the round-robin Hamming(11,7) encoder.
package hamming_encode_arbiter_pkg;
    localparam int DATA_W = 7;
    localparam int CODE_W = 11;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [CODE_W-1:0] code_t;
endpackage

// File: rtl/hamming_encode_arbiter_encoder.sv
// Combinational Hamming(11,7) encoder: data bits at 8,6,5,4,2,1,0, parity at 10,9,7,3.
module hamming_encoder
    import hamming_encode_arbiter_pkg::*;
(
    input  data_t data_i,
    output code_t code_o
);
    always_comb begin
        code_o     = '0;
        code_o[0]  = data_i[0];
        code_o[1]  = data_i[1];
        code_o[2]  = data_i[2];
        code_o[4]  = data_i[3];
        code_o[5]  = data_i[4];
        code_o[6]  = data_i[5];
        code_o[8]  = data_i[6];
        code_o[10] = data_i[6] ^ data_i[5] ^ data_i[3] ^ data_i[2] ^ data_i[0];
        code_o[9]  = data_i[6] ^ data_i[4] ^ data_i[3] ^ data_i[1] ^ data_i[0];
        code_o[7]  = data_i[5] ^ data_i[4] ^ data_i[3];
        code_o[3]  = data_i[2] ^ data_i[1] ^ data_i[0];
    end
endmodule

// File: rtl/hamming_encode_arbiter.sv
// Round-robin arbiter sharing one Hamming encoder among NUM_REQ requesters,
// with a single registered output slot that refills in the same cycle it drains.
module hamming_encode_arbiter
    import hamming_encode_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 16,
    parameter int ID_W    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CODE_W-1:0]         out_code,
    output logic [ID_W-1:0]           out_id,
    output logic [15:0]               word_count
);
    logic [NUM_REQ-1:0][DATA_W-1:0] words;
    logic [ID_W-1:0]                ptr_q, ptr_d;
    logic                           valid_q, valid_d;
    code_t                          code_q, code_d;
    logic [ID_W-1:0]                id_q, id_d;
    logic [15:0]                    count_q, count_d;

    logic            free, gnt, gnt_hit;
    logic [ID_W-1:0] gnt_idx;
    data_t           gnt_word;
    code_t           gnt_code;

    assign words = req_data;

    // Walk from the far end back toward ptr so the last hit is the first
    // valid requester at or after ptr (with wrap).
    always_comb begin
        gnt_hit = 1'b0;
        gnt_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[ID_W'((int'(ptr_q) + k) % NUM_REQ)]) begin
                gnt_hit = 1'b1;
                gnt_idx = ID_W'((int'(ptr_q) + k) % NUM_REQ);
            end
        end
    end

    assign free     = !rst && (!valid_q || out_ready);
    assign gnt      = free && gnt_hit;
    assign gnt_word = words[gnt_idx];

    always_comb begin
        req_ready = '0;
        if (gnt) req_ready[gnt_idx] = 1'b1;
    end

    hamming_encoder u_enc (
        .data_i (gnt_word),
        .code_o (gnt_code)
    );

    always_comb begin
        ptr_d   = ptr_q;
        valid_d = valid_q;
        code_d  = code_q;
        id_d    = id_q;
        count_d = count_q;
        if (valid_q && out_ready && count_q != 16'hFFFF) count_d = count_q + 16'd1;
        if (gnt) begin
            valid_d = 1'b1;
            code_d  = gnt_code;
            id_d    = gnt_idx;
            ptr_d   = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= '0;
            valid_q <= 1'b0;
            code_q  <= '0;
            id_q    <= '0;
            count_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            code_q  <= code_d;
            id_q    <= id_d;
            count_q <= count_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_code   = code_q;
    assign out_id     = id_q;
    assign word_count = count_q;
endmodule

// File: tb/tb_hamming_encode_arbiter.sv
// Randomized plus directed bench for hamming_encode_arbiter against a transaction-level model.
module tb_hamming_encode_arbiter;
    localparam int N = 16;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*7-1:0]  req_data;
    logic [N-1:0]    req_ready;
    logic            out_valid;
    logic            out_ready;
    logic [10:0]     out_code;
    logic [3:0]      out_id;
    logic [15:0]     word_count;

    int n_tests = 0;
    int n_fail  = 0;

    // model state
    int          m_ptr = 0;
    bit          m_ov  = 0;
    logic [10:0] m_code = '0;
    int          m_id  = 0;
    int          m_cnt = 0;

    hamming_encode_arbiter #(.NUM_REQ(N), .ID_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_code   (out_code),
        .out_id     (out_id),
        .word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [10:0] enc(input logic [6:0] d);
        logic [10:0] c;
        int dpos[7] = '{0, 1, 2, 4, 5, 6, 8};
        c = '0;
        for (int i = 0; i < 7; i++) c[dpos[i]] = d[i];
        c[10] = ^(d & 7'h6D);
        c[9]  = ^(d & 7'h5B);
        c[7]  = ^(d & 7'h38);
        c[3]  = ^(d & 7'h07);
        return c;
    endfunction

    function automatic int model_grant();
        if (rst || (m_ov && !out_ready)) return -1;
        for (int k = 0; k < N; k++) begin
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_word(input int i, input logic [6:0] w);
        req_data[i*7 +: 7] = w;
    endtask

    task automatic rand_data();
        for (int i = 0; i < N; i++) set_word(i, 7'($urandom));
    endtask

    // Compare DUT against the model, take one clock edge, advance the model.
    task automatic tick();
        int g;
        logic [N-1:0] exp_rdy;
        #1;
        g = model_grant();
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        check("out_valid", 32'(out_valid), 32'(m_ov));
        if (m_ov) begin
            check("out_code", 32'(out_code), 32'(m_code));
            check("out_id", 32'(out_id), 32'(m_id));
        end
        check("word_count", 32'(word_count), 32'(m_cnt));
        @(posedge clk);
        if (rst) begin
            m_ov = 0; m_code = '0; m_id = 0; m_ptr = 0; m_cnt = 0;
        end else begin
            if (m_ov && out_ready && m_cnt != 16'hFFFF) m_cnt++;
            if (g >= 0) begin
                m_ov   = 1;
                m_code = enc(req_data[g*7 +: 7]);
                m_id   = g;
                m_ptr  = (g + 1) % N;
            end else if (out_ready) begin
                m_ov = 0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_data = '0; out_ready = 1'b0;
        @(negedge clk);

        // model pins
        check("enc_pin_01", 32'(enc(7'h01)), 32'h609);
        check("enc_pin_08", 32'(enc(7'h08)), 32'h690);
        check("enc_pin_7f", 32'(enc(7'h7F)), 32'h7FF);

        // reset holds grants off even with every requester asking
        req_valid = '1; out_ready = 1'b1;
        tick(); tick();
        rst = 1'b0; req_valid = '0;
        #1 check("reset_out_valid", 32'(out_valid), 32'h0);
        check("reset_count", 32'(word_count), 32'h0);
        tick();

        // single requester
        set_word(3, 7'h01); req_valid = 16'h0008;
        #1 check("single_ready", 32'(req_ready), 32'h0008);
        tick();
        req_valid = '0;
        #1 check("single_code", 32'(out_code), 32'h609);
        check("single_id", 32'(out_id), 32'h3);
        tick();

        // fairness with everyone valid
        rst = 1'b1; tick(); rst = 1'b0;
        req_valid = '1; out_ready = 1'b1; rand_data();
        for (int k = 0; k <= N; k++) begin
            #1 check("rr_grant", 32'(req_ready), 32'(1) << (k % N));
            if (k > 0) check("rr_no_bubble", 32'(out_valid), 32'h1);
            tick();
        end

        // backpressure with 7'h08 pending from requester 6
        req_valid = 16'h0040; set_word(6, 7'h08);
        tick();
        out_ready = 1'b0; req_valid = '1;
        for (int k = 0; k < 5; k++) begin
            #1 check("bp_ready", 32'(req_ready), 32'h0);
            check("bp_code", 32'(out_code), 32'h690);
            check("bp_id", 32'(out_id), 32'h6);
            tick();
        end
        out_ready = 1'b1;
        #1 check("bp_release", 32'(req_ready), 32'h0080);
        tick();

        // wrap and skip: park ptr at 15 then offer 15 and 2
        req_valid = 16'h4000; tick();
        req_valid = 16'h8004;
        #1 check("wrap_15", 32'(req_ready), 32'h8000);
        tick();
        #1 check("wrap_2", 32'(req_ready), 32'h0004);
        tick();
        req_valid = '0; tick();

        // reset mid-stream discards the pending word
        req_valid = 16'h0200; out_ready = 1'b0; tick();
        req_valid = '0; rst = 1'b1; tick(); rst = 1'b0;
        req_valid = 16'h1020;
        #1 check("midrst_valid", 32'(out_valid), 32'h0);
        check("midrst_count", 32'(word_count), 32'h0);
        check("midrst_grant", 32'(req_ready), 32'h0020);
        tick();

        // all 128 words through random requesters
        out_ready = 1'b1;
        for (int w = 0; w < 128; w++) begin
            int i;
            i = $urandom_range(0, N - 1);
            rand_data(); set_word(i, 7'(w));
            req_valid = '0; req_valid[i] = 1'b1;
            tick();
        end
        req_valid = 16'h0001; set_word(0, 7'h7F); tick();
        req_valid = '0;
        #1 check("enc_7f", 32'(out_code), 32'h7FF);
        tick();

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 99) == 0);
            req_valid = N'($urandom);
            if ($urandom_range(0, 3) == 0) req_valid = '0;
            out_ready = ($urandom_range(0, 3) != 0);
            rand_data();
            tick();
        end
        rst = 1'b0; req_valid = '0; out_ready = 1'b1;
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
